// File: rtl/operate_uart_sender_pkg.sv
// Shared constants for the operate path: operate/target codes, UART framing
// constants, TX FSM state encodings and the queued command layout.
package operate_uart_sender_pkg;

  localparam logic [7:0] OPERATE_IGNORE = 8'h00;
  localparam logic [7:0] OPERATE_START  = 8'h01;
  localparam logic [7:0] OPERATE_STOP   = 8'h02;
  localparam logic [7:0] OPERATE_LEFT   = 8'h03;
  localparam logic [7:0] OPERATE_RIGHT  = 8'h04;
  localparam logic [7:0] OPERATE_FIRE   = 8'h05;

  localparam logic [7:0] TARGET_HOST    = 8'h1C;
  localparam logic [7:0] TARGET_PLAYER1 = 8'h21;
  localparam logic [7:0] TARGET_PLAYER2 = 8'h22;

  // start + 8 data + stop
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    UART_IDLE  = 3'd0,
    UART_START = 3'd1,
    UART_DATA  = 3'd2,
    UART_STOP  = 3'd3,
    UART_GAP   = 3'd4
  } uart_state_t;

  typedef struct packed {
    logic [7:0] target;
    logic [7:0] operate;
  } op_cmd_t;

  // Byte 0 goes out first and is the target; byte 1 is the operate code.
  function automatic logic [7:0] cmd_byte(input op_cmd_t cmd, input logic sel);
    return sel ? cmd.operate : cmd.target;
  endfunction

endpackage

// File: rtl/operate_uart_sender_op_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers; the head is readable
// combinationally so the TX FSM can pop and load in the same edge.
module op_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign dout = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/operate_uart_sender.sv
// Buffers verified operate commands and serialises each as a two-byte 8N1
// frame (target, then operate) followed by an idle gap; counts dropped commands.
module operate_uart_sender
  import operate_uart_sender_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int GAP_BITS     = 2
) (
  input  logic       uart_clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [7:0] data_operate_verified,
  input  logic [7:0] data_target,
  output logic       uart_tx,
  output logic       busy,
  output logic       fifo_full,
  output logic [7:0] drop_count
);

  localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_W   = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  uart_state_t        state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [2:0]         bit_idx_reg, bit_idx_next;
  logic               byte_sel_reg, byte_sel_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  op_cmd_t            shift_reg, shift_next;
  logic               tx_reg, tx_next;
  logic [7:0]         drop_count_reg;
  logic [7:0]         tx_byte;

  logic        push_req;
  logic        drop;
  logic        fifo_pop;
  logic        fifo_empty;
  logic        fifo_is_full;
  logic [15:0] fifo_dout;
  logic        bit_done;

  assign push_req = op_valid && (data_operate_verified != OPERATE_IGNORE);
  assign drop     = push_req && fifo_is_full && !fifo_pop;
  assign bit_done = (timer_reg == TIMER_LAST);

  op_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (uart_clk),
    .srst  (rst),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   ({data_target, data_operate_verified}),
    .dout  (fifo_dout),
    .full  (fifo_is_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      drop_count_reg <= '0;
    end else if (drop && (drop_count_reg != 8'hFF)) begin
      drop_count_reg <= drop_count_reg + 8'd1;
    end
  end

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state_reg    <= UART_IDLE;
      timer_reg    <= '0;
      bit_idx_reg  <= '0;
      byte_sel_reg <= 1'b0;
      gap_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      bit_idx_reg  <= bit_idx_next;
      byte_sel_reg <= byte_sel_next;
      gap_cnt_reg  <= gap_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg + 1'b1;
    bit_idx_next  = bit_idx_reg;
    byte_sel_next = byte_sel_reg;
    gap_cnt_next  = gap_cnt_reg;
    shift_next    = shift_reg;
    fifo_pop      = 1'b0;
    case (state_reg)
      UART_IDLE: begin
        timer_next = '0;
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          shift_next    = op_cmd_t'(fifo_dout);
          byte_sel_next = 1'b0;
          state_next    = UART_START;
        end
      end
      UART_START: begin
        if (bit_done) begin
          timer_next   = '0;
          bit_idx_next = '0;
          state_next   = UART_DATA;
        end
      end
      UART_DATA: begin
        if (bit_done) begin
          timer_next = '0;
          if (bit_idx_reg == 3'd7) begin
            state_next = UART_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      UART_STOP: begin
        if (bit_done) begin
          timer_next = '0;
          if (!byte_sel_reg) begin
            byte_sel_next = 1'b1;
            state_next    = UART_START;
          end else if (GAP_BITS == 0) begin
            state_next = UART_IDLE;
          end else begin
            gap_cnt_next = '0;
            state_next   = UART_GAP;
          end
        end
      end
      UART_GAP: begin
        if (bit_done) begin
          timer_next = '0;
          if (gap_cnt_reg == GAP_LAST) begin
            state_next = UART_IDLE;
          end else begin
            gap_cnt_next = gap_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = UART_IDLE;
        timer_next = '0;
      end
    endcase
  end

  // The line level is computed from the next state so the flop shows the
  // new bit in the same cycle the FSM enters it.
  always_comb begin
    tx_byte = cmd_byte(shift_next, byte_sel_next);
    tx_next = 1'b1;
    case (state_next)
      UART_START: tx_next = 1'b0;
      UART_DATA:  tx_next = tx_byte[bit_idx_next];
      default:    tx_next = 1'b1;
    endcase
  end

  assign uart_tx    = tx_reg;
  assign busy       = (state_reg != UART_IDLE) || !fifo_empty;
  assign fifo_full  = fifo_is_full;
  assign drop_count = drop_count_reg;

endmodule
